// File: rtl/dp_ram_pkg.sv
// Shared types and the lane-merge helper for the dual-port RAM.
package dp_ram_pkg;

    localparam int MERGE_W = 256;

    typedef enum logic [1:0] {
        RDW_READ_FIRST  = 2'd0,
        RDW_WRITE_FIRST = 2'd1,
        RDW_NO_CHANGE   = 2'd2
    } rdw_mode_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Callers zero-extend into MERGE_W and truncate the result back.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_W-1:0] be,
        input int                 byte_w
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_W; i++) begin
            if (be[8'(i / byte_w)]) res[i] = new_w[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/dp_ram_rport.sv
// Per-port read path: read-during-write selection, optional
// output stage and the read-valid strobe.
module dp_ram_rport
    import dp_ram_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rden,
    input  logic             wren,
    input  logic [WIDTH-1:0] old_word,
    input  logic [WIDTH-1:0] new_word,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid
);

    localparam bit WF = (RDW_MODE == int'(RDW_WRITE_FIRST));
    localparam bit NC = (RDW_MODE == int'(RDW_NO_CHANGE));

    logic             rd_fire;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s1_valid_q, s1_valid_d;

    always_comb begin
        rd_fire = en & rden;
        if (NC && wren) rd_fire = 1'b0;
        rd_word = old_word;
        if (WF && wren) rd_word = new_word;
        s1_data_d  = s1_data_q;
        s1_valid_d = rd_fire;
        if (rd_fire) s1_data_d = rd_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] s2_data_q, s2_data_d;
            logic             s2_valid_q, s2_valid_d;

            always_comb begin
                s2_data_d  = s2_data_q;
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) s2_data_d = s1_data_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_data_q  <= s2_data_d;
                    s2_valid_q <= s2_valid_d;
                end
            end

            assign rdata  = s2_data_q;
            assign rvalid = s2_valid_q;
        end else begin : g_noreg
            assign rdata  = s1_data_q;
            assign rvalid = s1_valid_q;
        end
    endgenerate

endmodule

// File: rtl/dp_ram_rdw.sv
// True dual-port RAM with byte enables, read-during-write modes
// and a reset-driven clear sweep.
module dp_ram_rdw
    import dp_ram_pkg::*;
#(
    parameter int               ABITS    = 4,
    parameter int               WIDTH    = 16,
    parameter int               BYTE_W   = 8,
    parameter int               RDW_MODE = 0,
    parameter int               OUT_REG  = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      init_busy,
    input  logic                      wren_a,
    input  logic                      rden_a,
    input  logic [WIDTH/BYTE_W-1:0]   be_a,
    input  logic [ABITS-1:0]          addr_a,
    input  logic [WIDTH-1:0]          wdata_a,
    output logic [WIDTH-1:0]          rdata_a,
    output logic                      rvalid_a,
    input  logic                      wren_b,
    input  logic                      rden_b,
    input  logic [WIDTH/BYTE_W-1:0]   be_b,
    input  logic [ABITS-1:0]          addr_b,
    input  logic [WIDTH-1:0]          wdata_b,
    output logic [WIDTH-1:0]          rdata_b,
    output logic                      rvalid_b
);

    localparam int DEPTH = 2 ** ABITS;
    localparam int NB    = WIDTH / BYTE_W;
    localparam int CW    = ABITS + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             ready, clr_en;
    logic             we_a, we_b, collide, wr_b_en;
    logic [WIDTH-1:0] old_a, old_b, new_a, new_b, wr_a_word;

    function automatic logic [WIDTH-1:0] merge(
        input logic [WIDTH-1:0] o,
        input logic [WIDTH-1:0] n,
        input logic [NB-1:0]    be
    );
        return WIDTH'(byte_merge(MERGE_W'(o), MERGE_W'(n),
                                 MERGE_W'(be), BYTE_W));
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DEPTH - 1)) state_d = ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_busy = (state_q == ST_CLEAR);

    // On a same-address double write, port A carries the combined word.
    always_comb begin
        ready     = (state_q == ST_READY) && !rst;
        clr_en    = (state_q == ST_CLEAR) && !rst;
        we_a      = ready & wren_a;
        we_b      = ready & wren_b;
        old_a     = mem_q[addr_a];
        old_b     = mem_q[addr_b];
        new_a     = merge(old_a, wdata_a, be_a);
        new_b     = merge(old_b, wdata_b, be_b);
        collide   = we_a & we_b & (addr_a == addr_b);
        wr_a_word = collide ? merge(new_b, wdata_a, be_a) : new_a;
        wr_b_en   = we_b & !collide;
    end

    always_ff @(posedge clk) begin
        if (clr_en) mem_q[cnt_q[ABITS-1:0]] <= INIT_VAL;
        if (we_a) mem_q[addr_a] <= wr_a_word;
        if (wr_b_en) mem_q[addr_b] <= new_b;
    end

    dp_ram_rport #(
        .WIDTH    (WIDTH),
        .RDW_MODE (RDW_MODE),
        .OUT_REG  (OUT_REG)
    ) u_rport_a (
        .clk      (clk),
        .rst      (rst),
        .en       (ready),
        .rden     (rden_a),
        .wren     (we_a),
        .old_word (old_a),
        .new_word (new_a),
        .rdata    (rdata_a),
        .rvalid   (rvalid_a)
    );

    dp_ram_rport #(
        .WIDTH    (WIDTH),
        .RDW_MODE (RDW_MODE),
        .OUT_REG  (OUT_REG)
    ) u_rport_b (
        .clk      (clk),
        .rst      (rst),
        .en       (ready),
        .rden     (rden_b),
        .wren     (we_b),
        .old_word (old_b),
        .new_word (new_b),
        .rdata    (rdata_b),
        .rvalid   (rvalid_b)
    );

endmodule

// File: tb/tb_dp_ram_rdw.sv
// Bench for dp_ram_rdw: three instances (read-first, write-first with
// output register, no-change) share stimulus and a reference model.
module tb_dp_ram_rdw;

    localparam logic [15:0] INIT = 16'hA5A5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wren_a, rden_a, wren_b, rden_b;
    logic [1:0]  be_a, be_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;

    logic        busy [3];
    logic [15:0] rda  [3];
    logic [15:0] rdb  [3];
    logic        rva  [3];
    logic        rvb  [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            dp_ram_rdw #(
                .ABITS    (4),
                .WIDTH    (16),
                .BYTE_W   (8),
                .RDW_MODE (g),
                .OUT_REG  ((g == 1) ? 1 : 0),
                .INIT_VAL (INIT)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .init_busy (busy[g]),
                .wren_a    (wren_a),
                .rden_a    (rden_a),
                .be_a      (be_a),
                .addr_a    (addr_a),
                .wdata_a   (wdata_a),
                .rdata_a   (rda[g]),
                .rvalid_a  (rva[g]),
                .wren_b    (wren_b),
                .rden_b    (rden_b),
                .be_b      (be_b),
                .addr_b    (addr_b),
                .wdata_b   (wdata_b),
                .rdata_b   (rdb[g]),
                .rvalid_b  (rvb[g])
            );
        end
    endgenerate

    typedef struct {
        logic wa, ra; logic [1:0] bea; logic [3:0] aa; logic [15:0] da;
        logic wb, rb; logic [1:0] beb; logic [3:0] ab; logic [15:0] db;
    } vec_t;

    typedef struct {
        vec_t in;
        logic [15:0] ead; logic eav;
        logic [15:0] ebd; logic ebv;
    } row_t;

    int total = 0;
    int bad   = 0;

    // Reference model: per instance a word array, clear counter and
    // a completion schedule indexed by cycle number.
    int          mode_m [3] = '{0, 1, 2};
    int          lat_m  [3] = '{1, 2, 1};
    logic [15:0] mm [3][16];
    int          clr_left [3];
    int          clr_addr [3];
    logic        sv [3][2][4];
    logic [15:0] sd [3][2][4];
    logic        ev [3][2];
    logic [15:0] ed [3][2];
    int          kcyc = 0;

    function automatic vec_t mkv(
        input logic wa, input logic ra, input logic [1:0] bea,
        input logic [3:0] aa, input logic [15:0] da,
        input logic wb, input logic rb, input logic [1:0] beb,
        input logic [3:0] ab, input logic [15:0] db);
        vec_t v;
        v.wa = wa; v.ra = ra; v.bea = bea; v.aa = aa; v.da = da;
        v.wb = wb; v.rb = rb; v.beb = beb; v.ab = ab; v.db = db;
        return v;
    endfunction

    function automatic row_t mkr(input vec_t v,
        input logic [15:0] ead, input logic eav,
        input logic [15:0] ebd, input logic ebv);
        row_t r;
        r.in = v; r.ead = ead; r.eav = eav; r.ebd = ebd; r.ebv = ebv;
        return r;
    endfunction

    function automatic logic [15:0] mix(input logic [15:0] o,
        input logic [15:0] n, input logic [1:0] be);
        logic [15:0] r;
        r = o;
        for (int j = 0; j < 2; j++)
            if (be[j]) r[j*8 +: 8] = n[j*8 +: 8];
        return r;
    endfunction

    task automatic set_in(input vec_t x);
        wren_a = x.wa; rden_a = x.ra; be_a = x.bea;
        addr_a = x.aa; wdata_a = x.da;
        wren_b = x.wb; rden_b = x.rb; be_b = x.beb;
        addr_b = x.ab; wdata_b = x.db;
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        logic        w [2];
        logic        r [2];
        logic [1:0]  be [2];
        logic [3:0]  ad [2];
        logic [15:0] wd [2];
        int          s;
        w[0] = wren_a; r[0] = rden_a; be[0] = be_a;
        ad[0] = addr_a; wd[0] = wdata_a;
        w[1] = wren_b; r[1] = rden_b; be[1] = be_b;
        ad[1] = addr_b; wd[1] = wdata_b;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                clr_left[i] = 16;
                clr_addr[i] = 0;
                for (int p = 0; p < 2; p++) begin
                    ev[i][p] = 1'b0;
                    ed[i][p] = 16'h0;
                    for (int q = 0; q < 4; q++) sv[i][p][q] = 1'b0;
                end
            end else begin
                if (clr_left[i] > 0) begin
                    mm[i][clr_addr[i]] = INIT;
                    clr_addr[i]++;
                    clr_left[i]--;
                end else begin
                    for (int p = 0; p < 2; p++) begin
                        if (r[p] && !(w[p] && mode_m[i] == 2)) begin
                            s = (kcyc + lat_m[i] - 1) % 4;
                            sv[i][p][s] = 1'b1;
                            sd[i][p][s] = (w[p] && mode_m[i] == 1)
                                ? mix(mm[i][ad[p]], wd[p], be[p])
                                : mm[i][ad[p]];
                        end
                    end
                    // B first, then A on top: A owns its enabled lanes.
                    if (w[1]) mm[i][ad[1]] = mix(mm[i][ad[1]], wd[1], be[1]);
                    if (w[0]) mm[i][ad[0]] = mix(mm[i][ad[0]], wd[0], be[0]);
                end
                s = kcyc % 4;
                for (int p = 0; p < 2; p++) begin
                    ev[i][p] = sv[i][p][s];
                    if (sv[i][p][s]) ed[i][p] = sd[i][p][s];
                    sv[i][p][s] = 1'b0;
                end
            end
        end
        kcyc++;
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy%0d", i), 16'(busy[i]),
                16'(clr_left[i] > 0));
            chk($sformatf("rdata_a%0d", i), rda[i], ed[i][0]);
            chk($sformatf("rvalid_a%0d", i), 16'(rva[i]), 16'(ev[i][0]));
            chk($sformatf("rdata_b%0d", i), rdb[i], ed[i][1]);
            chk($sformatf("rvalid_b%0d", i), 16'(rvb[i]), 16'(ev[i][1]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.wa = 1'($urandom_range(0, 1));
        v.ra = 1'($urandom_range(0, 1));
        v.bea = 2'($urandom_range(0, 3));
        v.aa = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3))
                                           : 4'($urandom_range(0, 15));
        v.da = 16'($urandom);
        v.wb = 1'($urandom_range(0, 1));
        v.rb = 1'($urandom_range(0, 1));
        v.beb = 2'($urandom_range(0, 3));
        v.ab = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3))
                                           : 4'($urandom_range(0, 15));
        v.db = 16'($urandom);
        return v;
    endfunction

    row_t tbl [13];
    vec_t idle;
    int   n;

    initial begin
        idle = mkv(0, 0, 2'b00, 4'h0, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
        tbl[0]  = mkr(mkv(0,1,2'b00,4'hF,16'h0,   0,0,2'b00,4'h0,16'h0),
                      16'hA5A5, 1, 16'h0000, 0);
        tbl[1]  = mkr(mkv(1,0,2'b11,4'h3,16'h1234,0,0,2'b00,4'h0,16'h0),
                      16'hA5A5, 0, 16'h0000, 0);
        tbl[2]  = mkr(mkv(1,0,2'b01,4'h3,16'hBEEF,0,0,2'b00,4'h0,16'h0),
                      16'hA5A5, 0, 16'h0000, 0);
        tbl[3]  = mkr(mkv(0,1,2'b00,4'h3,16'h0,   0,0,2'b00,4'h0,16'h0),
                      16'h12EF, 1, 16'h0000, 0);
        tbl[4]  = mkr(mkv(1,0,2'b11,4'h5,16'h0001,0,0,2'b00,4'h0,16'h0),
                      16'h12EF, 0, 16'h0000, 0);
        tbl[5]  = mkr(mkv(1,1,2'b11,4'h5,16'h0002,0,0,2'b00,4'h0,16'h0),
                      16'h0001, 1, 16'h0000, 0);
        tbl[6]  = mkr(mkv(0,1,2'b00,4'h5,16'h0,   0,0,2'b00,4'h0,16'h0),
                      16'h0002, 1, 16'h0000, 0);
        tbl[7]  = mkr(mkv(1,0,2'b10,4'h7,16'hAAAA,1,0,2'b11,4'h7,16'hBBBB),
                      16'h0002, 0, 16'h0000, 0);
        tbl[8]  = mkr(mkv(0,0,2'b00,4'h0,16'h0,   0,1,2'b00,4'h7,16'h0),
                      16'h0002, 0, 16'hAABB, 1);
        tbl[9]  = mkr(mkv(1,0,2'b11,4'h7,16'h1111,0,1,2'b00,4'h7,16'h0),
                      16'h0002, 0, 16'hAABB, 1);
        tbl[10] = mkr(mkv(0,0,2'b00,4'h0,16'h0,   0,1,2'b00,4'h7,16'h0),
                      16'h0002, 0, 16'h1111, 1);
        tbl[11] = mkr(mkv(1,1,2'b00,4'h7,16'hFFFF,0,0,2'b00,4'h0,16'h0),
                      16'h1111, 1, 16'h1111, 0);
        tbl[12] = mkr(mkv(0,0,2'b00,4'h0,16'h0,   0,1,2'b00,4'h7,16'h0),
                      16'h1111, 0, 16'h1111, 1);

        // reset and first sweep
        rst = 1'b1;
        set_in(idle);
        tick();
        chk("rst_busy", 16'(busy[0]), 16'h1);
        chk("rst_rdata_a", rda[0], 16'h0);
        chk("rst_rvalid_b", 16'(rvb[1]), 16'h0);
        rst = 1'b0;
        n = 0;
        while (busy[0] && n < 40) begin
            tick();
            n++;
        end
        chk("sweep_len", 16'(n), 16'd16);

        // table-driven vectors, checked against instance 0
        for (int r = 0; r < 13; r++) begin
            set_in(tbl[r].in);
            tick();
            chk($sformatf("tbl%0d_rda", r), rda[0], tbl[r].ead);
            chk($sformatf("tbl%0d_rva", r), 16'(rva[0]), 16'(tbl[r].eav));
            chk($sformatf("tbl%0d_rdb", r), rdb[0], tbl[r].ebd);
            chk($sformatf("tbl%0d_rvb", r), 16'(rvb[0]), 16'(tbl[r].ebv));
        end

        // read-during-write across the three modes
        set_in(mkv(1,0,2'b11,4'h9,16'h0001,0,0,2'b00,4'h0,16'h0));
        tick();
        set_in(mkv(0,1,2'b00,4'h9,16'h0,   0,0,2'b00,4'h0,16'h0));
        tick();
        set_in(mkv(1,1,2'b11,4'h9,16'h0002,0,0,2'b00,4'h0,16'h0));
        tick();
        chk("rf_data", rda[0], 16'h0001);
        chk("rf_valid", 16'(rva[0]), 16'h1);
        chk("nc_valid", 16'(rva[2]), 16'h0);
        chk("nc_hold", rda[2], 16'h0001);
        chk("wf_prev", rda[1], 16'h0001);
        set_in(idle);
        tick();
        chk("wf_data", rda[1], 16'h0002);
        chk("wf_valid", 16'(rva[1]), 16'h1);
        chk("rf_idle_valid", 16'(rva[0]), 16'h0);
        set_in(mkv(0,1,2'b00,4'h9,16'h0,   0,0,2'b00,4'h0,16'h0));
        tick();
        chk("nc_later", rda[2], 16'h0002);
        chk("nc_later_v", 16'(rva[2]), 16'h1);

        // two-cycle latency on the registered instance
        for (int a = 0; a < 3; a++) begin
            set_in(mkv(1,0,2'b11,4'(a),16'h1000 + 16'(a),
                       0,0,2'b00,4'h0,16'h0));
            tick();
        end
        set_in(idle);
        tick();
        set_in(mkv(0,1,2'b00,4'h0,16'h0,0,0,2'b00,4'h0,16'h0));
        tick();
        chk("lat_c1_v", 16'(rva[1]), 16'h0);
        for (int a = 1; a < 5; a++) begin
            if (a < 3) set_in(mkv(0,1,2'b00,4'(a),16'h0,
                                  0,0,2'b00,4'h0,16'h0));
            else set_in(idle);
            tick();
            chk($sformatf("lat_c%0d_v", a + 1), 16'(rva[1]),
                16'(a < 4));
            chk($sformatf("lat_c%0d_d", a + 1), rda[1],
                16'h1000 + 16'((a < 4) ? a - 1 : 2));
        end
        set_in(mkv(0,1,2'b00,4'h1,16'h0,0,0,2'b00,4'h0,16'h0));
        tick();
        n = int'(rva[1]);
        set_in(idle);
        for (int c = 0; c < 4; c++) begin
            tick();
            n += int'(rva[1]);
        end
        chk("single_pulse", 16'(n), 16'd1);

        // reset while the sweep is at address 9; busy-time writes are lost
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(mkv(1,0,2'b11,4'h0,16'h7777,1,0,2'b11,4'h3,16'h8888));
        n = 0;
        while (busy[0] && n < 40) begin
            tick();
            n++;
        end
        chk("resweep_len", 16'(n), 16'd16);
        set_in(mkv(0,1,2'b00,4'h0,16'h0,0,1,2'b00,4'h3,16'h0));
        tick();
        chk("lost_wr_a", rda[0], INIT);
        chk("lost_wr_b", rdb[0], INIT);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_in(rand_vec());
            tick();
        end
        rst = 1'b0;
        set_in(idle);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
